ibex_fetch_req_ctrl: RTL
========================

Name: ibex_fetch_req_ctrl

Overview:
Request sequencer that drives the instruction-side bus (OBI-style req/gnt/rvalid) and feeds the fetch FIFO (clear/valid/addr/rdata/err inputs).
- Issues word-aligned sequential fetches.
- Bounds outstanding requests against FIFO occupancy.
- Redirects on branches and discards stale in-flight responses.
- Sits between the IF-stage core interface and the fetch FIFO.

Parameters:
NUM_REQS, 2, max outstanding bus requests; matches the fetch FIFO NUM_REQS; width of the fifo_busy_i vector.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
req_i  in  1  fetch enable from core
branch_i  in  1  redirect strobe, single cycle
branch_addr_i  in  32  redirect target, halfword aligned
fifo_busy_i  in  NUM_REQS  FIFO busy vector, bit k set = FIFO entry k+1 occupied
fifo_clear_o  out  1  FIFO clear
fifo_valid_o  out  1  push response into FIFO
fifo_addr_o  out  32  FIFO restart address
fifo_rdata_o  out  32  response data to FIFO
fifo_err_o  out  1  response error to FIFO
instr_req_o  out  1  bus request
instr_gnt_i  in  1  bus grant
instr_addr_o  out  32  bus address, bits[1:0]=0
instr_rvalid_i  in  1  bus response valid
instr_rdata_i  in  32  bus response data
instr_err_i  in  1  bus response error
busy_o  out  1  request pending or responses outstanding

Behaviour:
Clock and reset (decided):
- Clock is clk_i.
- Reset is rst_ni: asynchronous, active-low.
- Reset values: outstanding_q=0, discard_q=0, state=IDLE, fetch_addr_q=0.
- Resulting outputs: instr_req_o=0, fifo_valid_o=0, busy_o=0.

Redirect and FIFO interface:
- fifo_clear_o = branch_i (combinational).
- fifo_addr_o = branch_addr_i (combinational).
- fifo_rdata_o = instr_rdata_i; fifo_err_o = instr_err_i (pass-through).

Outstanding and discard tracking:
- outstanding_q[NUM_REQS-1:0] is a thermometer code, LSB = oldest.
- Grant shifts a 1 in at the top of the filled region.
- Each rvalid shifts right by one.
- Grant and rvalid in the same cycle: count is unchanged, vector is realigned.
- discard_q is parallel to outstanding_q.
- On branch_i, discard_q |= outstanding_q, and also the slot being granted that cycle if its request used the pre-branch address.

FIFO push:
- fifo_valid_o = instr_rvalid_i & outstanding_q[0] & ~discard_q[0] & ~branch_i.
- A branch in the response cycle drops that response.
- rvalid with outstanding_q[0]=0 is ignored; flag it with an assertion.

Issue condition:
- occ[k] = fifo_busy_i[k] | outstanding_q[k].
- can_issue = req_i & ~&occ & ~outstanding_q[NUM_REQS-1].

FSM:
- IDLE: instr_req_o = can_issue | (branch_i & req_i).
  - No grant → go to WAIT_GNT.
  - Grant → stay in IDLE.
- WAIT_GNT: instr_req_o = 1 and instr_addr_o is held stable until grant.
  - Exception: branch_i replaces the address with the new target the same cycle.
  - Grant → IDLE.
  - req_i deassertion does not drop a pending request.

Address:
- instr_addr_o = branch_i ? {branch_addr_i[31:2],2'b00} : fetch_addr_q.
- On grant: fetch_addr_q <= instr_addr_o + 4, 32-bit wrap (0xFFFF_FFFC → 0x0).
- On branch without grant: fetch_addr_q <= aligned target.

Boundary conditions:
- FIFO full: no request is raised.
- Branch while outstanding=NUM_REQS: request waits for a free slot; the redirect address is remembered in fetch_addr_q.

Status:
- busy_o = instr_req_o | (|outstanding_q).

Optional Feature:
IBEX_FETCH_ERR_STOP_EN
- Defined:
  - A pushed response with fifo_err_o=1 sets err_stop_q.
  - err_stop_q blocks new requests; a request already in WAIT_GNT still completes.
  - branch_i clears err_stop_q.
  - Reset value is 0.
- Undefined: errors are forwarded only and fetching continues sequentially.

Decomposition:
- Package ibex_fetch_pkg:
  - fetch_req_state_e {IDLE, WAIT_GNT}.
  - FETCH_WORD_MASK = 32'hFFFF_FFFC.
- Sub-module ibex_fetch_outstanding_tracker (param NUM_REQS):
  - Inputs: grant, rvalid, branch, grant_stale.
  - Outputs: outstanding_q, discard_q.

Test Plan:
1. Reset, then req_i=1, branch to 0x100, gnt always 1, rvalid 1 cycle after gnt, FIFO empty → instr_addr 0x100, 0x104, 0x108; fifo_valid_o each response; outstanding ≤ 2.
2. gnt held low 3 cycles → instr_req_o=1 and instr_addr_o=0x104 stable all 3 cycles; a 3rd request is never issued while outstanding=2.
3. Two outstanding (0x200, 0x204), branch_i to 0x402 → fifo_clear_o=1, fifo_addr_o=0x402, instr_addr_o=0x400; both old responses give fifo_valid_o=0; first new response is pushed.
4. fifo_busy_i=2'b11, outstanding=0 → instr_req_o=0; busy drops to 2'b01 → request issued next cycle.
5. rvalid and branch_i in the same cycle → fifo_valid_o=0; an rvalid with outstanding=0 is not pushed.
6. With IBEX_FETCH_ERR_STOP_EN: response err=1 → no further requests; branch to 0x80 → requests resume at 0x80. Without the macro → requests continue at +4.

Source files
------------

// File: rtl/ibex_fetch_pkg.sv
// Shared types and constants for the instruction fetch request sequencer.
package ibex_fetch_pkg;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_GNT
    } fetch_req_state_e;

    localparam logic [31:0] FETCH_WORD_MASK = 32'hFFFF_FFFC;

    // Force an address onto a word boundary.
    function automatic logic [31:0] fetch_word_align(input logic [31:0] addr);
        return addr & FETCH_WORD_MASK;
    endfunction

endpackage

// File: rtl/ibex_fetch_outstanding_tracker.sv
// Tracks in-flight bus requests as a thermometer code (LSB = oldest) plus a
// parallel discard vector marking responses that must not reach the FIFO.
module ibex_fetch_outstanding_tracker #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                grant_i,
    input  logic                rvalid_i,
    input  logic                branch_i,
    input  logic                grant_stale_i,
    output logic [NUM_REQS-1:0] outstanding_o,
    output logic [NUM_REQS-1:0] discard_o
);

    localparam logic [NUM_REQS-1:0] ONE = {{(NUM_REQS-1){1'b0}}, 1'b1};

    logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
    logic [NUM_REQS-1:0] discard_q, discard_d;
    logic [NUM_REQS-1:0] new_slot;
    logic [NUM_REQS-1:0] out_g, disc_g;
    logic                pop;

    // Next state: apply branch marking and grant first, then retire the oldest slot.
    always_comb begin
        pop      = rvalid_i & outstanding_q[0];
        // First empty slot above the filled thermometer region.
        new_slot = ~outstanding_q & ((outstanding_q << 1) | ONE);
        out_g    = outstanding_q;
        disc_g   = discard_q;
        if (branch_i) begin
            disc_g = disc_g | outstanding_q;
        end
        if (grant_i) begin
            out_g = outstanding_q | new_slot;
            if (grant_stale_i) begin
                disc_g = disc_g | new_slot;
            end
        end
        outstanding_d = pop ? (out_g >> 1) : out_g;
        discard_d     = pop ? (disc_g >> 1) : disc_g;
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign outstanding_o = outstanding_q;
    assign discard_o     = discard_q;

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction-side bus request sequencer feeding the fetch FIFO.
// Optional: define IBEX_FETCH_ERR_STOP_EN to halt fetching after an error
// response until the next branch.
module ibex_fetch_req_ctrl
    import ibex_fetch_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         branch_addr_i,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,
    output logic                busy_o
);

    fetch_req_state_e    state_q, state_d;
    logic [31:0]         fetch_addr_q, fetch_addr_d;
    logic [31:0]         branch_target;
    logic [NUM_REQS-1:0] outstanding;
    logic [NUM_REQS-1:0] discard;
    logic [NUM_REQS-1:0] occ;
    logic                can_issue;
    logic                grant;
    logic                grant_stale;
    logic                err_stop;
    logic                unused_discard;

    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = branch_addr_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

    assign branch_target = fetch_word_align(branch_addr_i);
    assign instr_addr_o  = branch_i ? branch_target : fetch_addr_q;

    assign occ       = fifo_busy_i | outstanding;
    assign can_issue = req_i & ~(&occ) & ~outstanding[NUM_REQS-1];
    assign grant     = instr_req_o & instr_gnt_i;
    // The bus address always follows a same-cycle branch, so a grant only
    // carries a stale address if that ever stops holding.
    assign grant_stale = branch_i & (instr_addr_o != branch_target);

    assign fifo_valid_o = instr_rvalid_i & outstanding[0] & ~discard[0] & ~branch_i;
    assign busy_o       = instr_req_o | (|outstanding);

    // Only the oldest discard bit decides a push; younger bits shift down into it.
    assign unused_discard = ^discard[NUM_REQS-1:1];

    ibex_fetch_outstanding_tracker #(
        .NUM_REQS (NUM_REQS)
    ) u_tracker (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .grant_i       (grant),
        .rvalid_i      (instr_rvalid_i),
        .branch_i      (branch_i),
        .grant_stale_i (grant_stale),
        .outstanding_o (outstanding),
        .discard_o     (discard)
    );

`ifdef IBEX_FETCH_ERR_STOP_EN
    logic err_stop_q, err_stop_d;

    // Latch an error on a pushed response; a redirect restarts fetching.
    always_comb begin
        err_stop_d = err_stop_q;
        if (branch_i) begin
            err_stop_d = 1'b0;
        end else if (fifo_valid_o && instr_err_i) begin
            err_stop_d = 1'b1;
        end
    end

    // Error-stop register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_stop_q <= 1'b0;
        end else begin
            err_stop_q <= err_stop_d;
        end
    end

    assign err_stop = err_stop_q;
`else
    assign err_stop = 1'b0;
`endif

    // Request FSM and fetch address next state.
    always_comb begin
        state_d      = state_q;
        instr_req_o  = 1'b0;
        fetch_addr_d = fetch_addr_q;
        unique case (state_q)
            IDLE: begin
                // A branch empties the FIFO, so only a free outstanding slot matters.
                instr_req_o = (can_issue & ~err_stop) |
                              (branch_i & req_i & ~outstanding[NUM_REQS-1]);
                if (instr_req_o && !instr_gnt_i) begin
                    state_d = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                instr_req_o = 1'b1;
                if (instr_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant) begin
            fetch_addr_d = fetch_word_align(instr_addr_o + 32'd4);
        end else if (branch_i) begin
            fetch_addr_d = branch_target;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            fetch_addr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

`ifdef INC_ASSERT
    // Responses without a matching request are dropped; flag them when checking.
    assert property (@(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> outstanding[0]);
`endif

endmodule
